// File: rtl/cube_root_controller_if.sv
// Handshake and result bundle for the cube-root controller.
// The master drives the request side, and the slave (the controller) drives the status and result side.
interface cube_root_controller_if;
  logic        start;
  logic [31:0] radicand;
  logic        busy;
  logic        done;
  logic [10:0] root;
  logic [32:0] remainder;
  logic [3:0]  iter;

  modport master (
    output start, radicand,
    input  busy, done, root, remainder, iter
  );

  modport slave (
    input  start, radicand,
    output busy, done, root, remainder, iter
  );
endinterface

// File: rtl/cube_root_controller.sv
// Sequential digit-by-digit floor cube root of a 32-bit unsigned operand.
// Each of the 11 three-bit groups takes one FACTOR cycle and one COMPARE cycle.
module cube_root_controller (
  input  logic                    clk,
  input  logic                    clear_n,
  cube_root_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FACTOR  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] rad_q, rad_d;
  logic [10:0] root_q, root_d;
  logic [32:0] rem_q, rem_d;
  logic [3:0]  iter_q, iter_d;
  logic [32:0] trial_q, trial_d;
  logic [32:0] factor_q, factor_d;

  logic [3:0]  grp;
  logic [5:0]  shamt;
  logic [2:0]  grp_bits;
  logic [32:0] a;
  logic [32:0] factor_calc;
  logic [32:0] trial_calc;
  logic        fits;

  // The group index counts down from 10, so the most significant group is handled first.
  assign grp         = 4'd10 - iter_q;
  assign shamt       = 6'(grp) * 6'd3;
  assign grp_bits    = 3'(rad_q >> shamt);
  assign a           = {21'b0, root_q, 1'b0};
  assign factor_calc = (a * a * 33'd3) + (a * 33'd3) + 33'd1;
  assign trial_calc  = {rem_q[29:0], grp_bits};
  assign fits        = (trial_q >= factor_q);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= IDLE;
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      trial_q  <= '0;
      factor_q <= '0;
    end else begin
      state_q  <= state_d;
      rad_q    <= rad_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      trial_q  <= trial_d;
      factor_q <= factor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rad_d    = rad_q;
    root_d   = root_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    trial_d  = trial_q;
    factor_d = factor_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          rad_d   = {1'b0, bus.radicand};
          root_d  = '0;
          rem_d   = '0;
          iter_d  = '0;
          state_d = FACTOR;
        end
      end
      FACTOR: begin
        trial_d  = trial_calc;
        factor_d = factor_calc;
        state_d  = COMPARE;
      end
      COMPARE: begin
        if (fits) begin
          rem_d  = trial_q - factor_q;
          root_d = {root_q[9:0], 1'b1};
        end else begin
          rem_d  = trial_q;
          root_d = {root_q[9:0], 1'b0};
        end
        if (iter_q == 4'd10) begin
          state_d = DONE;
        end else begin
          iter_d  = iter_q + 4'd1;
          state_d = FACTOR;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.root      = root_q;
  assign bus.remainder = rem_q;
  assign bus.iter      = iter_q;

endmodule

// File: tb/tb_cube_root_controller.sv
// Directed bench for cube_root_controller with hand-computed roots and remainders.
// It covers reset values, latency, held start, a mid-run abort and boundary operands.
module tb_cube_root_controller;

  logic clk;
  logic clear_n;
  int unsigned vectors;
  int unsigned miscompares;

  cube_root_controller_if bus ();

  cube_root_controller dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and wait for done at negedges.
  // Done should first appear at the 23rd negedge after the accepting edge.
  task automatic run_op(input string tag, input logic [31:0] rad,
                        input logic [10:0] exp_root, input logic [32:0] exp_rem);
    int cycles;
    int busy_low;
    logic seen;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = rad;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.radicand = 32'h5A5A_5A5A;
    cycles   = 0;
    busy_low = 0;
    seen     = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (!bus.busy) busy_low++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, " done_latency"}, 64'(cycles), 64'd23);
    check({tag, " busy_gaps"}, 64'(busy_low), 64'd0);
    check({tag, " root"}, 64'(bus.root), 64'(exp_root));
    check({tag, " remainder"}, 64'(bus.remainder), 64'(exp_rem));
    check({tag, " iter_at_done"}, 64'(bus.iter), 64'd10);
    @(negedge clk);
    check({tag, " done_single"}, 64'(bus.done), 64'd0);
    check({tag, " idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, " root_hold"}, 64'(bus.root), 64'(exp_root));
    check({tag, " rem_hold"}, 64'(bus.remainder), 64'(exp_rem));
  endtask

  initial begin
    int cycles;
    int done_cnt;
    logic seen;

    vectors      = 0;
    miscompares  = 0;
    bus.start    = 1'b0;
    bus.radicand = '0;
    clear_n      = 1'b0;
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset root", 64'(bus.root), 64'd0);
    check("reset rem", 64'(bus.remainder), 64'd0);
    check("reset iter", 64'(bus.iter), 64'd0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle hold busy", 64'(bus.busy), 64'd0);

    run_op("r27", 32'd27, 11'd3, 33'd0);
    run_op("r28", 32'd28, 11'd3, 33'd1);
    run_op("r1000", 32'd1000, 11'd10, 33'd0);
    run_op("r0", 32'd0, 11'd0, 33'd0);
    run_op("r1", 32'd1, 11'd1, 33'd0);
    run_op("r26", 32'd26, 11'd2, 33'd18);
    run_op("r999999", 32'd999999, 11'd99, 33'd29700);
    run_op("r2p30", 32'd1073741824, 11'd1024, 33'd0);
    run_op("r2p30m1", 32'd1073741823, 11'd1023, 33'd3142656);
    run_op("rmax", 32'hFFFF_FFFF, 11'd1625, 33'd3951670);

    // start held high: 64 captured first, then 125 on the edge after done returns to IDLE
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 32'd64;
    @(posedge clk);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (cycles == 5) bus.radicand = 32'd125;
      if (bus.done) seen = 1'b1;
    end
    check("held first latency", 64'(cycles), 64'd23);
    check("held first root", 64'(bus.root), 64'd4);
    check("held first rem", 64'(bus.remainder), 64'd0);
    @(negedge clk);
    check("held idle gap", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("held reaccept busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    cycles = 2;
    seen   = 1'b0;
    while (!seen && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (bus.done) seen = 1'b1;
    end
    check("held second latency", 64'(cycles), 64'd24);
    check("held second root", 64'(bus.root), 64'd5);
    check("held second rem", 64'(bus.remainder), 64'd0);

    // Abort mid-run: clear_n falls shortly after the 9th edge past acceptance.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.radicand = 32'd27;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    clear_n = 1'b0;
    #1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort done", 64'(bus.done), 64'd0);
    check("abort root", 64'(bus.root), 64'd0);
    check("abort rem", 64'(bus.remainder), 64'd0);
    check("abort iter", 64'(bus.iter), 64'd0);
    @(negedge clk);
    clear_n  = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    check("abort no done", 64'(done_cnt), 64'd0);
    run_op("r8 after abort", 32'd8, 11'd2, 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cube_root_controller.md
CUBE_ROOT_CONTROLLER -- requirements
Module: cube_root_controller

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clear_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin one cube-root operation, sampled only in IDLE.
REQ-005 radicand  input  32  unsigned operand, captured on the accepting edge.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle completion pulse.
REQ-008 root  output  11  floor cube root of the captured radicand.
REQ-009 remainder  output  33  radicand minus root cubed.
REQ-010 iter  output  4  index of the current iteration, 0..10.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, FACTOR, COMPARE and DONE.
REQ-012 IDLE with start=1 SHALL capture the radicand zero-extended to 33 bits, clear root, remainder and iter to 0, and go to FACTOR.
REQ-013 IDLE with start=0 SHALL hold every register.
REQ-014 Iteration k (0..10) SHALL use 3-bit group g = 10-k, i.e. bits [3g+2:3g] of the 33-bit radicand, most significant group first.
REQ-015 FACTOR SHALL register trial_rem = (remainder<<3)|group and factor = 3*a*a + 3*a + 1, with a = root<<1, then go to COMPARE.
REQ-016 Both factor and trial_rem SHALL be computed at 33-bit width with no truncation; in iteration 0 root=0, so factor=1.
REQ-017 COMPARE with trial_rem >= factor (unsigned) SHALL set remainder = trial_rem - factor and root = (root<<1)|1.
REQ-018 COMPARE with trial_rem < factor SHALL set remainder = trial_rem and root = root<<1.
REQ-019 COMPARE with iter=10 SHALL go to DONE; with any other iter it SHALL increment iter and go to FACTOR.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-021 Latency: start is sampled at edge E0; done SHALL be high from edge E0+22 to E0+23 (11 iterations x 2 cycles).
REQ-022 root and remainder SHALL stay stable from DONE until the next accepted start, and SHALL be updated only during COMPARE.
REQ-023 start SHALL be ignored in FACTOR, COMPARE and DONE; there is no queuing, so start must be reasserted in IDLE.
REQ-024 radicand SHALL be ignored except on the accepting edge; changes during an operation have no effect.
REQ-025 A start asserted in the cycle immediately after done SHALL be accepted, giving back-to-back operations with no bubble beyond IDLE.
REQ-026 After each COMPARE, remainder SHALL equal (radicand >> 3g) - root^3 and SHALL be at most 3*root^2 + 3*root.
REQ-027 iter SHALL never exceed 10 and SHALL not wrap.

Reset
REQ-028 While clear_n=0, asynchronously and independent of clk: state = IDLE; busy, done, root, remainder and iter = 0; internal trial_rem, factor and captured radicand = 0.
REQ-029 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-030 After clear_n deasserts, the first rising edge with start=1 SHALL begin a fresh operation.

Verification
REQ-031 radicand=27, start pulsed -> done at E0+22, root=3, remainder=0, busy high E0..E0+22.
REQ-032 radicand=28 -> root=3, remainder=1; radicand=1000 -> root=10, remainder=0; radicand=0 -> root=0, remainder=0.
REQ-033 radicand=0xFFFFFFFF -> root=1625, remainder=3951670 (exercises the widest factor and remainder).
REQ-034 start held high throughout, radicand changed mid-run from 64 to 125 -> first result root=4, remainder=0; second operation accepted the edge after done and captures 125 -> root=5.
REQ-035 clear_n pulsed low at E0+9 -> outputs zero immediately, no done; a new start with radicand=8 -> root=2, remainder=0 at its own E0+22.
REQ-036 Random radicands (>=10k) against a reference model -> root^3 <= radicand < (root+1)^3, remainder = radicand - root^3, done exactly once per accepted start.
